// File: rtl/svc_rv_alu_arb_pkg.sv
// Shared definitions for the arbitrated RV32I ALU: op encodings and op width.
package svc_rv_alu_arb_pkg;

  localparam int ALU_OP_W = 3;

  typedef enum logic [ALU_OP_W-1:0] {
    ALU_ADD = 3'd0,
    ALU_SUB = 3'd1,
    ALU_AND = 3'd2,
    ALU_OR  = 3'd3,
    ALU_XOR = 3'd4,
    ALU_SLT = 3'd5
  } alu_op_e;

endpackage

// File: rtl/svc_rr_arb.sv
// Round-robin arbiter: grants the first asserted request at or after ptr,
// wrapping around; reusable for any shared resource.
module svc_rr_arb #(
  parameter int NREQ = 3,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  input  logic            en,
  output logic [NREQ-1:0] grant,
  output logic [IDW-1:0]  idx
);

  logic found;
  int   j;

  always_comb begin
    grant = '0;
    idx   = '0;
    found = 1'b0;
    j     = 0;
    for (int k = 0; k < NREQ; k++) begin
      j = int'(ptr) + k;
      if (j >= NREQ) j = j - NREQ;
      if (en && !found && req[j]) begin
        grant[j] = 1'b1;
        idx      = IDW'(j);
        found    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/svc_rv_alu.sv
// Combinational RV32I-style ALU subset: ADD, SUB, AND, OR, XOR and signed SLT.
module svc_rv_alu
  import svc_rv_alu_arb_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0]     a,
  input  logic [XLEN-1:0]     b,
  input  logic [ALU_OP_W-1:0] op,
  output logic [XLEN-1:0]     result
);

  logic signed [XLEN-1:0] a_s;
  logic signed [XLEN-1:0] b_s;

  assign a_s = a;
  assign b_s = b;

  always_comb begin
    result = '0;
    case (op)
      ALU_ADD: result = a + b;
      ALU_SUB: result = a - b;
      ALU_AND: result = a & b;
      ALU_OR:  result = a | b;
      ALU_XOR: result = a ^ b;
      ALU_SLT: result = {{(XLEN-1){1'b0}}, (a_s < b_s)};
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/svc_rv_alu_arb.sv
// Shares one svc_rv_alu among NREQ requesters via round-robin; result held in a
// single id-tagged output slot. Optional lock feature: SVC_RV_ALU_ARB_LOCK_EN.
module svc_rv_alu_arb
  import svc_rv_alu_arb_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int NREQ = 3,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NREQ-1:0]          req_valid,
  output logic [NREQ-1:0]          req_ready,
  input  logic [NREQ*XLEN-1:0]     req_a,
  input  logic [NREQ*XLEN-1:0]     req_b,
  input  logic [NREQ*ALU_OP_W-1:0] req_op,
`ifdef SVC_RV_ALU_ARB_LOCK_EN
  input  logic [NREQ-1:0]          req_lock,
`endif
  output logic                     res_valid,
  input  logic                     res_ready,
  output logic [IDW-1:0]           res_id,
  output logic [XLEN-1:0]          res_result
);

  logic                free;
  logic                arb_en;
  logic [NREQ-1:0]     grant;
  logic [IDW-1:0]      gnt_idx;
  logic                xfer;
  logic [XLEN-1:0]     alu_a;
  logic [XLEN-1:0]     alu_b;
  logic [ALU_OP_W-1:0] alu_op;
  logic [XLEN-1:0]     alu_res;

  logic [IDW-1:0]  ptr_d, ptr_q;
  logic            res_valid_d, res_valid_q;
  logic [IDW-1:0]  res_id_d, res_id_q;
  logic [XLEN-1:0] res_result_d, res_result_q;

  assign free   = !res_valid_q || res_ready;
  assign arb_en = free && !rst;

  svc_rr_arb #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_arb (
    .req   (req_valid),
    .ptr   (ptr_q),
    .en    (arb_en),
    .grant (grant),
    .idx   (gnt_idx)
  );

  assign req_ready = grant;
  assign xfer      = |grant;

  // Stage 0: granted operands drive the shared ALU in the transfer cycle
  assign alu_a  = req_a[int'(gnt_idx)*XLEN +: XLEN];
  assign alu_b  = req_b[int'(gnt_idx)*XLEN +: XLEN];
  assign alu_op = req_op[int'(gnt_idx)*ALU_OP_W +: ALU_OP_W];

  svc_rv_alu #(
    .XLEN (XLEN)
  ) u_alu (
    .a      (alu_a),
    .b      (alu_b),
    .op     (alu_op),
    .result (alu_res)
  );

  // A locked winner keeps the pointer; if it then drops valid while the slot is
  // free, the scan from the pointer naturally hands the grant onward.
  always_comb begin
    ptr_d = ptr_q;
    if (xfer) begin
      ptr_d = (gnt_idx == IDW'(NREQ-1)) ? '0 : gnt_idx + IDW'(1);
`ifdef SVC_RV_ALU_ARB_LOCK_EN
      if (req_lock[gnt_idx]) ptr_d = gnt_idx;
`endif
    end
  end

  always_comb begin
    res_valid_d  = res_valid_q;
    res_id_d     = res_id_q;
    res_result_d = res_result_q;
    if (xfer) begin
      res_valid_d  = 1'b1;
      res_id_d     = gnt_idx;
      res_result_d = alu_res;
    end else if (res_ready) begin
      res_valid_d  = 1'b0;
    end
  end

  // Stage 1: registered result slot
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q        <= '0;
      res_valid_q  <= 1'b0;
      res_id_q     <= '0;
      res_result_q <= '0;
    end else begin
      ptr_q        <= ptr_d;
      res_valid_q  <= res_valid_d;
      res_id_q     <= res_id_d;
      res_result_q <= res_result_d;
    end
  end

  assign res_valid  = res_valid_q;
  assign res_id     = res_id_q;
  assign res_result = res_result_q;

endmodule

// File: tb/tb_svc_rv_alu_arb.sv
// Self-checking bench for svc_rv_alu_arb: directed steps followed by random traffic
// checked against a behavioural model of the arbitration and result slot.
module tb_svc_rv_alu_arb;
  import svc_rv_alu_arb_pkg::*;

  localparam int XLEN = 32;
  localparam int NREQ = 3;
  localparam int IDW  = 2;

  logic                     clk = 1'b0;
  logic                     rst;
  logic [NREQ-1:0]          req_valid;
  logic [NREQ-1:0]          req_ready;
  logic [NREQ*XLEN-1:0]     req_a;
  logic [NREQ*XLEN-1:0]     req_b;
  logic [NREQ*ALU_OP_W-1:0] req_op;
`ifdef SVC_RV_ALU_ARB_LOCK_EN
  logic [NREQ-1:0]          req_lock = '0;
`endif
  logic                     res_valid;
  logic                     res_ready;
  logic [IDW-1:0]           res_id;
  logic [XLEN-1:0]          res_result;

  always #5 clk = ~clk;

  svc_rv_alu_arb #(.XLEN(XLEN), .NREQ(NREQ), .IDW(IDW)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_a      (req_a),
    .req_b      (req_b),
    .req_op     (req_op),
`ifdef SVC_RV_ALU_ARB_LOCK_EN
    .req_lock   (req_lock),
`endif
    .res_valid  (res_valid),
    .res_ready  (res_ready),
    .res_id     (res_id),
    .res_result (res_result)
  );

  int n_assert = 0;
  int n_fail   = 0;

  // Behavioural model: result slot, rotating priority, pending request per requester
  logic            m_valid;
  logic [IDW-1:0]  m_id;
  logic [XLEN-1:0] m_res;
  int              m_ptr;
  logic            pv  [NREQ];
  logic [XLEN-1:0] pa  [NREQ];
  logic [XLEN-1:0] pb  [NREQ];
  logic [2:0]      pop [NREQ];
  int              last_g;
  bit              refill;

  function automatic logic [XLEN-1:0] ref_alu(input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                                              input logic [2:0] op);
    longint sa, sb;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (op)
      ALU_ADD: return a + b;
      ALU_SUB: return a + ~b + XLEN'(1);
      ALU_AND: return a & b;
      ALU_OR:  return a | b;
      ALU_XOR: return a ^ b;
      ALU_SLT: return (sa < sb) ? XLEN'(1) : XLEN'(0);
      default: return '0;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [XLEN-1:0] obs, input logic [XLEN-1:0] exp);
    n_assert++;
    assert (obs === exp)
      else begin
        n_fail++;
        $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
  endtask

  task automatic new_req(input int i, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                         input logic [2:0] op);
    pv[i] = 1'b1; pa[i] = a; pb[i] = b; pop[i] = op;
  endtask

  task automatic new_rand_req(input int i);
    logic [2:0] op;
    op = 3'($urandom_range(0, 5));
    new_req(i, $urandom, ($urandom_range(0, 3) == 0) ? XLEN'($urandom_range(0, 2)) : $urandom, op);
  endtask

  task automatic drive();
    for (int i = 0; i < NREQ; i++) begin
      req_valid[i]                     = pv[i];
      req_a[i*XLEN +: XLEN]            = pa[i];
      req_b[i*XLEN +: XLEN]            = pb[i];
      req_op[i*ALU_OP_W +: ALU_OP_W]   = pop[i];
    end
  endtask

  // One clock: check slot, present requests, check grant, advance model
  task automatic cycle();
    int g;
    logic free;
    logic [NREQ-1:0] exp_rdy;
    chk("res_valid", XLEN'(res_valid), XLEN'(m_valid));
    if (m_valid) begin
      chk("res_id", XLEN'(res_id), XLEN'(m_id));
      chk("res_result", res_result, m_res);
    end
    drive();
    #1;
    g = -1;
    free = !m_valid || res_ready;
    if (!rst && free)
      for (int k = 0; k < NREQ; k++) begin
        int j = (m_ptr + k) % NREQ;
        if (g < 0 && pv[j]) g = j;
      end
    exp_rdy = '0;
    if (g >= 0) exp_rdy[g] = 1'b1;
    chk("req_ready", XLEN'(req_ready), XLEN'(exp_rdy));
    last_g = g;
    if (rst) begin
      m_valid = 1'b0; m_id = '0; m_res = '0; m_ptr = 0;
    end else if (g >= 0) begin
      m_res   = ref_alu(pa[g], pb[g], pop[g]);
      m_id    = g[IDW-1:0];
      m_valid = 1'b1;
      m_ptr   = (g + 1) % NREQ;
      pv[g]   = 1'b0;
      if (refill) new_rand_req(g);
    end else if (res_ready) begin
      m_valid = 1'b0;
    end
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int seq [4];
    logic [XLEN-1:0] held;
    logic any_pv;

    rst = 1'b1; res_ready = 1'b1; refill = 1'b0;
    m_valid = 1'b0; m_id = '0; m_res = '0; m_ptr = 0;
    for (int i = 0; i < NREQ; i++) new_rand_req(i);
    drive();
    @(posedge clk); #1;

    // Reset: no grants even with all requesters valid, slot cleared
    cycle(); cycle();
    chk("rst_res_valid", XLEN'(res_valid), '0);
    chk("rst_res_id", XLEN'(res_id), '0);
    chk("rst_res_result", res_result, '0);
    for (int i = 0; i < NREQ; i++) pv[i] = 1'b0;
    rst = 1'b0;

    // Single request: 5 + 7
    new_req(0, 32'd5, 32'd7, ALU_ADD);
    cycle();
    chk("single_grant", XLEN'(last_g), 32'd0);
    chk("single_valid", XLEN'(res_valid), 32'd1);
    chk("single_id", XLEN'(res_id), 32'd0);
    chk("single_result", res_result, 32'd12);

    rst = 1'b1; cycle(); rst = 1'b0;

    // Round-robin with all requesters continuously valid
    refill = 1'b1;
    for (int i = 0; i < NREQ; i++) new_rand_req(i);
    for (int k = 0; k < 4; k++) begin
      cycle();
      seq[k] = last_g;
      chk("rr_no_bubble", XLEN'(res_valid), 32'd1);
    end
    chk("rr_grant0", XLEN'(seq[0]), 32'd0);
    chk("rr_grant1", XLEN'(seq[1]), 32'd1);
    chk("rr_grant2", XLEN'(seq[2]), 32'd2);
    chk("rr_grant3", XLEN'(seq[3]), 32'd0);
    refill = 1'b0;

    // Backpressure: slot full, no grants, result held; one release loads next
    res_ready = 1'b0;
    held = res_result;
    for (int k = 0; k < 3; k++) cycle();
    chk("bp_hold_result", res_result, held);
    chk("bp_hold_id", XLEN'(res_id), 32'd0);
    res_ready = 1'b1;
    cycle();
    chk("bp_release_grant", XLEN'(last_g), 32'd1);
    chk("bp_release_id", XLEN'(res_id), 32'd1);
    res_ready = 1'b0;
    cycle();
    chk("bp_regrant_none", XLEN'(last_g), 32'hFFFF_FFFF);
    res_ready = 1'b1;

    // Drain leftovers (bounded), then arithmetic corners
    for (int k = 0; k < 10; k++) begin
      any_pv = 1'b0;
      for (int i = 0; i < NREQ; i++) any_pv |= pv[i];
      if (any_pv) cycle();
    end
    any_pv = 1'b0;
    for (int i = 0; i < NREQ; i++) any_pv |= pv[i];
    chk("drain_done", XLEN'(any_pv), 32'd0);
    cycle();
    chk("drain_valid_clear", XLEN'(res_valid), 32'd0);

    new_req(1, 32'd0, 32'd1, ALU_SUB);
    cycle();
    chk("sub_wrap", res_result, 32'hFFFF_FFFF);
    new_req(2, 32'h8000_0000, 32'd1, ALU_SLT);
    cycle();
    chk("slt_signed", res_result, 32'd1);
    chk("slt_id", XLEN'(res_id), 32'd2);

    // Reset mid-flight with pointer at 2
    new_req(1, 32'd3, 32'd4, ALU_XOR);
    cycle();
    chk("mid_valid", XLEN'(res_valid), 32'd1);
    rst = 1'b1; cycle(); rst = 1'b0;
    chk("mid_rst_valid", XLEN'(res_valid), 32'd0);
    for (int i = 0; i < NREQ; i++) new_rand_req(i);
    cycle();
    chk("mid_rst_grant0", XLEN'(last_g), 32'd0);

    // Random traffic
    for (int n = 0; n < 400; n++) begin
      for (int i = 0; i < NREQ; i++)
        if (!pv[i] && $urandom_range(0, 1) == 1) new_rand_req(i);
      res_ready = ($urandom_range(0, 3) != 0);
      rst = ($urandom_range(0, 63) == 0);
      cycle();
    end
    rst = 1'b0; res_ready = 1'b1;
    cycle(); cycle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
